// File: rtl/evt_pulse_qualifier_if.sv
`default_nettype none
// ============================================================
// evt_pulse_qualifier_if : event line, controls and status of the qualifier
// Rev 1.0
// ============================================================
interface evt_pulse_qualifier_if #(
  parameter int PEND_W = 4
);
  logic              evt_in;
  logic              enable;
  logic              clear;
  logic              count;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              busy;

  modport master (
    output evt_in, enable, clear,
    input  count, pending, overflow, busy
  );

  modport slave (
    input  evt_in, enable, clear,
    output count, pending, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/evt_pulse_qualifier.sv
`default_nettype none
// ============================================================
// evt_pulse_qualifier : sync + debounce + queued, spaced count pulses
// Rev 1.0
// ============================================================
module evt_pulse_qualifier #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int PEND_W          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  evt_pulse_qualifier_if.slave  bus
);

  localparam int c_db_w  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
  localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  c_pend_max = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [c_db_w-1:0]      r_db_cnt;
  state_t                 r_state;
  logic [c_gap_w-1:0]     r_gap_cnt;
  logic [PEND_W-1:0]      r_pending;
  logic                   r_overflow;
  logic                   r_count;

  logic w_s;
  logic w_db_hit;
  logic w_qual_edge;
  logic w_pend_nz;
  logic w_gap_done;
  logic w_start;

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_db_hit    = (w_s != r_filt) && (r_db_cnt == c_db_last);
  // filt only moves on a hit, so a hit with s high is the 0->1 update
  assign w_qual_edge = w_db_hit && w_s;
  assign w_pend_nz   = |r_pending;
  assign w_gap_done  = (r_state == ST_GAP) && (r_gap_cnt == c_gap_last);
  assign w_start     = bus.enable && w_pend_nz && ((r_state == ST_IDLE) || w_gap_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_filt   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.evt_in};
      if (w_s == r_filt) begin
        r_db_cnt <= '0;
      end else if (w_db_hit) begin
        r_filt   <= w_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_count    <= 1'b0;
    end else if (bus.clear) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_count    <= 1'b0;
    end else begin
      r_count <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_PULSE;
            r_count <= 1'b1;
          end
        end
        ST_PULSE: begin
          r_state   <= ST_GAP;
          r_gap_cnt <= '0;
        end
        ST_GAP: begin
          if (w_gap_done) begin
            if (w_start) begin
              r_state <= ST_PULSE;
              r_count <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // a simultaneous queue and emit cancels out, even when saturated
      if (w_qual_edge && !w_start) begin
        if (r_pending == c_pend_max) r_overflow <= 1'b1;
        else                         r_pending  <= r_pending + 1'b1;
      end else if (w_start && !w_qual_edge) begin
        r_pending <= r_pending - 1'b1;
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state != ST_IDLE) || w_pend_nz;

endmodule
`default_nettype wire

// File: tb/tb_evt_pulse_qualifier.sv
`default_nettype none
// ============================================================
// tb_evt_pulse_qualifier : directed + random bench with window/timing model
// Rev 1.0
// ============================================================
module tb_evt_pulse_qualifier;

  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int GAP  = 2;
  localparam int PW   = 4;
  localparam int PMAX = 15;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  evt_pulse_qualifier_if #(.PEND_W(PW)) ifc ();

  evt_pulse_qualifier #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAP), .PEND_W(PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state: raw-sample delay line, window of synced samples,
  // pending as a plain integer, and the time of the last emitted pulse
  bit m_sync_q[$];
  bit m_win[$];
  int since_flip;
  bit m_filt;
  int m_pend;
  bit m_ovf;
  int lp;
  int t;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    m_sync_q.delete();
    for (int i = 0; i < SS; i++) m_sync_q.push_back(1'b0);
    m_win.delete();
    since_flip = 0;
    m_filt     = 1'b0;
    m_pend     = 0;
    m_ovf      = 1'b0;
    lp         = -1000;
  endtask

  task automatic check_outputs();
    chk("count",    32'(ifc.count),    (lp == t) ? 1 : 0);
    chk("pending",  32'(ifc.pending),  m_pend);
    chk("overflow", 32'(ifc.overflow), m_ovf ? 1 : 0);
    chk("busy",     32'(ifc.busy),     ((t - lp) <= GAP || m_pend != 0) ? 1 : 0);
  endtask

  task automatic tick();
    bit s;
    bit qe;
    bit start;
    bit all_diff;
    @(posedge clk);
    t++;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_sync_q.pop_front();
      m_sync_q.push_back(ifc.evt_in);
      m_win.push_back(s);
      if (m_win.size() > DB) void'(m_win.pop_front());
      since_flip++;
      qe       = 1'b0;
      all_diff = (m_win.size() == DB);
      foreach (m_win[i]) if (m_win[i] == m_filt) all_diff = 1'b0;
      if (all_diff && since_flip >= DB) begin
        m_filt     = !m_filt;
        since_flip = 0;
        qe         = m_filt;
      end
      if (ifc.clear) begin
        m_pend = 0;
        m_ovf  = 1'b0;
        lp     = -1000;
      end else begin
        start = ifc.enable && (m_pend != 0) && ((t - lp) >= GAP + 1);
        if (qe && !start) begin
          if (m_pend == PMAX) m_ovf = 1'b1;
          else                m_pend++;
        end else if (start && !qe) begin
          m_pend--;
        end
        if (start) lp = t;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic pulse_evt(input int hi, input int lo);
    ifc.evt_in = 1'b1;
    repeat (hi) tick();
    ifc.evt_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic clear_once();
    ifc.clear = 1'b1;
    tick();
    ifc.clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int prev;
    bit found;
    n_vec = 0;
    n_err = 0;
    t     = 0;
    rst_n      = 1'b0;
    ifc.evt_in = 1'b0;
    ifc.enable = 1'b0;
    ifc.clear  = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // single event: E0 is the first tick after evt_in rises
    ifc.enable = 1'b1;
    ifc.evt_in = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ifc.count) pulses++;
      if (k == 4) chk("single_pend_e4", 32'(ifc.pending), 0);
      if (k == 5) chk("single_pend_e5", 32'(ifc.pending), 1);
      if (k == 5) chk("single_cnt_e5",  32'(ifc.count), 0);
      if (k == 6) chk("single_cnt_e6",  32'(ifc.count), 1);
      if (k == 6) chk("single_pend_e6", 32'(ifc.pending), 0);
      if (k == 8) chk("single_busy_e8", 32'(ifc.busy), 1);
      if (k == 9) chk("single_busy_e9", 32'(ifc.busy), 0);
    end
    chk("single_pulses", pulses, 1);
    ifc.evt_in = 1'b0;
    repeat (10) tick();

    // glitch shorter than the debounce window
    pulses = 0;
    ifc.evt_in = 1'b1;
    repeat (3) tick();
    ifc.evt_in = 1'b0;
    repeat (15) begin tick(); if (ifc.count) pulses++; end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_pend", 32'(ifc.pending), 0);

    // queue five events with enable low, then release
    ifc.enable = 1'b0;
    pulses = 0;
    repeat (5) begin
      pulse_evt(8, 8);
    end
    chk("queue_pend", 32'(ifc.pending), 5);
    ifc.enable = 1'b1;
    prev = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ifc.count) begin
        pulses++;
        if (prev >= 0) chk("queue_spacing", t - prev, GAP + 1);
        prev = t;
      end
    end
    chk("queue_pulses", pulses, 5);
    chk("queue_drain", 32'(ifc.pending), 0);

    // saturation and clear
    ifc.enable = 1'b0;
    clear_once();
    for (int n = 1; n <= 17; n++) begin
      pulse_evt(8, 8);
      if (n == 15) chk("sat_ovf_15", 32'(ifc.overflow), 0);
      if (n == 15) chk("sat_pend_15", 32'(ifc.pending), 15);
      if (n == 16) chk("sat_ovf_16", 32'(ifc.overflow), 1);
    end
    chk("sat_pend_17", 32'(ifc.pending), 15);
    chk("sat_ovf_17", 32'(ifc.overflow), 1);
    clear_once();
    chk("clr_pend", 32'(ifc.pending), 0);
    chk("clr_ovf", 32'(ifc.overflow), 0);

    // qualified edge coincides with the FSM entering PULSE at max
    repeat (15) pulse_evt(8, 8);
    ifc.evt_in = 1'b1;
    repeat (5) tick();
    ifc.enable = 1'b1;
    tick();
    chk("incdec_pend", 32'(ifc.pending), 15);
    chk("incdec_ovf", 32'(ifc.overflow), 0);
    chk("incdec_cnt", 32'(ifc.count), 1);
    ifc.evt_in = 1'b0;
    repeat (60) tick();

    // reset while a pulse is out and three are still queued
    ifc.enable = 1'b0;
    clear_once();
    repeat (4) pulse_evt(8, 8);
    ifc.enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ifc.count) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_wait_pulse", found ? 1 : 0, 1);
    chk("rst_pre_pend", 32'(ifc.pending), 3);
    rst_n = 1'b0;
    #1;
    chk("rst_cnt", 32'(ifc.count), 0);
    chk("rst_pend", 32'(ifc.pending), 0);
    chk("rst_ovf", 32'(ifc.overflow), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin tick(); if (ifc.count) pulses++; end
    chk("rst_no_pulse", pulses, 0);

    // random levels, enables and occasional clears
    for (int i = 0; i < 300; i++) begin
      ifc.evt_in = 1'($urandom_range(0, 1));
      ifc.enable = ($urandom_range(0, 3) != 0);
      ifc.clear  = ($urandom_range(0, 40) == 0);
      repeat ($urandom_range(1, 12)) begin
        tick();
        ifc.clear = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
